// File: rtl/bc_pass_ctrl_if.sv
// Bus bundle for bc_pass_ctrl: run control, pixel loader stream, host
// readback, square-generator port requests and the box-count RAM ports.
//   slave  : the controller side (bc_pass_ctrl)
//   master : the environment side (host, loader, square generator, RAM)
interface bc_pass_ctrl_if #(
  parameter int BOX_IDX  = 3,
  parameter int DATA_LEN = 8
);
  localparam int AW = 2*BOX_IDX+1;

  // run control / status
  logic                start;
  logic                abort;
  logic                busy;
  logic                done;
  logic [AW-1:0]       wr_count;
  // pixel loader
  logic                ld_valid;
  logic [DATA_LEN-1:0] ld_data;
  logic                ld_ready;
  // host readback
  logic                hr_valid;
  logic [AW-1:0]       hr_addr;
  logic                hr_ready;
  logic                hr_rvalid;
  logic [DATA_LEN-1:0] hr_rdata;
  // square generator
  logic                sqg_wen;
  logic [DATA_LEN-1:0] sqg_y;
  logic [AW-1:0]       sqg_rd_addr;
  logic [AW-1:0]       sqg_wr_addr;
  logic                bc_mode;
  // box-count RAM
  logic                ram_wen;
  logic [AW-1:0]       ram_wr_addr;
  logic [DATA_LEN-1:0] ram_wdata;
  logic [AW-1:0]       ram_rd_addr;
  logic [DATA_LEN-1:0] ram_rdata;

  modport slave (
    input  start, abort, ld_valid, ld_data, hr_valid, hr_addr,
           sqg_wen, sqg_y, sqg_rd_addr, sqg_wr_addr, ram_rdata,
    output busy, done, wr_count, ld_ready, hr_ready, hr_rvalid, hr_rdata,
           bc_mode, ram_wen, ram_wr_addr, ram_wdata, ram_rd_addr
  );

  modport master (
    output start, abort, ld_valid, ld_data, hr_valid, hr_addr,
           sqg_wen, sqg_y, sqg_rd_addr, sqg_wr_addr, ram_rdata,
    input  busy, done, wr_count, ld_ready, hr_ready, hr_rvalid, hr_rdata,
           bc_mode, ram_wen, ram_wr_addr, ram_wdata, ram_rd_addr
  );
endinterface

// File: rtl/bc_pass_ctrl.sv
// bc_pass_ctrl: sequencer and RAM port arbiter for one box-counting run.
//   IDLE  -> host owns the read port, nothing writes.
//   LOAD  -> loader stream writes 4**BOX_IDX pixel counts into the lower
//            half of each row pair (address bit BOX_IDX forced to 0).
//   REDUCE-> square generator released (bc_mode=0) for REDUCE_CYCLES
//            cycles and owns both RAM ports; its writes are counted.
//   DONE  -> host readback again; wr_count holds the pass write total.
// Ports: CLK, RST (async, active high) plus the bc_pass_ctrl_if slave
// modport carrying every handshake, status and RAM signal.
module bc_pass_ctrl #(
  parameter int BOX_IDX       = 3,
  parameter int DATA_LEN      = 8,
  parameter int REDUCE_CYCLES = 2**(2*BOX_IDX+1)
) (
  input logic           CLK,
  input logic           RST,
  bc_pass_ctrl_if.slave bus
);
  localparam int AW = 2*BOX_IDX+1;
  localparam int PW = 2*BOX_IDX;
  localparam int CW = (REDUCE_CYCLES > 1) ? $clog2(REDUCE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, REDUCE, DONE} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ld_cnt_q, ld_cnt_d;
  logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [AW-1:0] wr_count_q, wr_count_d;
  logic          bc_mode_q, bc_mode_d;
  logic          hr_rvalid_q;

  logic ld_fire, host_side;

  assign host_side = (state_q == IDLE) || (state_q == DONE);
  assign ld_fire   = (state_q == LOAD) && bus.ld_valid;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      ld_cnt_q    <= '0;
      cyc_cnt_q   <= '0;
      wr_count_q  <= '0;
      bc_mode_q   <= 1'b1;
      hr_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      wr_count_q  <= wr_count_d;
      bc_mode_q   <= bc_mode_d;
      // a read accepted just before an abort still returns its data
      hr_rvalid_q <= bus.hr_valid && host_side;
    end
  end

  always_comb begin
    state_d    = state_q;
    ld_cnt_d   = ld_cnt_q;
    cyc_cnt_d  = cyc_cnt_q;
    wr_count_d = wr_count_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d    = LOAD;
          ld_cnt_d   = '0;
          wr_count_d = '0;
        end
      end
      LOAD: begin
        if (ld_fire) begin
          ld_cnt_d = ld_cnt_q + 1'b1;
          if (&ld_cnt_q) begin
            state_d   = REDUCE;
            cyc_cnt_d = '0;
          end
        end
      end
      REDUCE: begin
        cyc_cnt_d = cyc_cnt_q + 1'b1;
        if (bus.sqg_wen && (wr_count_q != '1))
          wr_count_d = wr_count_q + 1'b1;
        if (cyc_cnt_q == CW'(REDUCE_CYCLES-1)) begin
          state_d   = DONE;
          cyc_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // abort overrides everything, including a same-cycle start
    if (bus.abort) begin
      state_d    = IDLE;
      ld_cnt_d   = '0;
      cyc_cnt_d  = '0;
      wr_count_d = wr_count_q;
    end
    // registered so the generator is released exactly on REDUCE entry
    bc_mode_d = (state_d != REDUCE);
  end

  // RAM port mux: loader / square generator / host
  always_comb begin
    bus.ram_wen     = 1'b0;
    bus.ram_wr_addr = '0;
    bus.ram_wdata   = '0;
    bus.ram_rd_addr = bus.hr_addr;
    if (state_q == LOAD) begin
      bus.ram_wen     = ld_fire;
      bus.ram_wr_addr = {ld_cnt_q[PW-1:BOX_IDX], 1'b0, ld_cnt_q[BOX_IDX-1:0]};
      bus.ram_wdata   = bus.ld_data;
    end else if (state_q == REDUCE) begin
      bus.ram_wen     = bus.sqg_wen;
      bus.ram_wr_addr = bus.sqg_wr_addr;
      bus.ram_wdata   = bus.sqg_y;
      bus.ram_rd_addr = bus.sqg_rd_addr;
    end
  end

  assign bus.ld_ready  = (state_q == LOAD);
  assign bus.hr_ready  = host_side;
  assign bus.hr_rvalid = hr_rvalid_q;
  assign bus.hr_rdata  = bus.ram_rdata;
  assign bus.bc_mode   = bc_mode_q;
  assign bus.busy      = (state_q == LOAD) || (state_q == REDUCE);
  assign bus.done      = (state_q == DONE);
  assign bus.wr_count  = wr_count_q;
endmodule

// File: tb/tb_bc_pass_ctrl.sv
// Scoreboard bench for bc_pass_ctrl (BOX_IDX=3, DATA_LEN=8, 128 cycles).
// Stimulus pushes expected RAM writes / host read data into queues; the
// negedge monitor pops them whenever ram_wen or hr_rvalid is seen.
module tb_bc_pass_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  bc_pass_ctrl_if #(.BOX_IDX(3), .DATA_LEN(8)) bus();

  bc_pass_ctrl #(.BOX_IDX(3), .DATA_LEN(8), .REDUCE_CYCLES(128)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  // RAM stub: one-cycle read latency, address 0x0C holds 0x2A
  always @(posedge CLK)
    bus.ram_rdata <= (bus.ram_rd_addr == 7'h0C) ? 8'h2A : {1'b0, bus.ram_rd_addr};

  int n_chk  = 0;
  int n_fail = 0;
  logic [14:0] wr_q[$];   // {addr, data}
  logic [7:0]  rd_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.ram_wen === 1'b1) begin
        if (wr_q.size() == 0) chk("unexpected_write", {bus.ram_wr_addr, bus.ram_wdata}, 32'hFFFF_FFFF);
        else chk("ram_write", {bus.ram_wr_addr, bus.ram_wdata}, wr_q.pop_front());
      end
      if (bus.hr_rvalid === 1'b1) begin
        if (rd_q.size() == 0) chk("unexpected_rvalid", bus.hr_rdata, 32'hFFFF_FFFF);
        else chk("hr_rdata", bus.hr_rdata, rd_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  // 64 loader beats, ld_data = k; optional bubble (with a stray sqg_wen) before beat bubble_at
  task automatic do_load(input int bubble_at);
    logic [7:0] kk;
    for (int k = 0; k < 64; k++) begin
      if (k == bubble_at) begin
        bus.ld_valid = 1'b0; bus.sqg_wen = 1'b1;
        step();
        bus.sqg_wen = 1'b0;
      end
      kk = k[7:0];
      bus.ld_valid = 1'b1; bus.ld_data = kk;
      wr_q.push_back({kk[5:3], 1'b0, kk[2:0], kk});
      if (k == 9) begin
        #1;
        chk("beat9_addr", bus.ram_wr_addr, 7'b001_0_001);
        chk("beat9_data", bus.ram_wdata, 8'd9);
      end
      step();
    end
    bus.ld_valid = 1'b0;
    chk("post_load_ld_ready", bus.ld_ready, 1'b0);
    chk("post_load_bc_mode", bus.bc_mode, 1'b0);
    chk("post_load_busy", bus.busy, 1'b1);
  endtask

  // n REDUCE cycles, sqg write on every 4th cycle (addr c, data c+1)
  task automatic do_reduce(input int n);
    logic [7:0] cc;
    for (int c = 0; c < n; c++) begin
      cc = c[7:0];
      bus.sqg_wen     = (c % 4 == 0);
      bus.sqg_wr_addr = cc[6:0];
      bus.sqg_y       = cc + 8'd1;
      bus.sqg_rd_addr = 7'd127 - cc[6:0];
      if (c % 4 == 0) wr_q.push_back({cc[6:0], cc + 8'd1});
      if (c == 1) begin #1; chk("reduce_rd_addr", bus.ram_rd_addr, 7'd126); end
      if (c == 10) begin
        bus.hr_valid = 1'b1; bus.hr_addr = 7'h0C;
        #1; chk("reduce_hr_ready", bus.hr_ready, 1'b0);
      end
      step();
      bus.hr_valid = 1'b0;
    end
    bus.sqg_wen = 1'b0;
  endtask

  initial begin
    bus.start = 0; bus.abort = 0; bus.ld_valid = 0; bus.ld_data = 0;
    bus.hr_valid = 0; bus.hr_addr = 0; bus.sqg_wen = 0; bus.sqg_y = 0;
    bus.sqg_rd_addr = 0; bus.sqg_wr_addr = 0;
    step(); step();
    chk("rst_bc_mode", bus.bc_mode, 1'b1);
    chk("rst_ld_ready", bus.ld_ready, 1'b0);
    chk("rst_hr_rvalid", bus.hr_rvalid, 1'b0);
    chk("rst_wr_count", bus.wr_count, 7'd0);
    chk("rst_ram_wen", bus.ram_wen, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    RST = 1'b0;
    step();

    // stray generator write in IDLE must not reach the RAM
    bus.sqg_wen = 1'b1; #1;
    chk("idle_sqg_isolated", bus.ram_wen, 1'b0);
    step(); bus.sqg_wen = 1'b0;

    // first run: back-to-back load, full reduce
    bus.start = 1'b1; step(); bus.start = 1'b0;
    chk("load_ld_ready", bus.ld_ready, 1'b1);
    chk("load_hr_ready", bus.hr_ready, 1'b0);
    do_load(-1);
    do_reduce(128);
    chk("done_flag", bus.done, 1'b1);
    chk("done_bc_mode", bus.bc_mode, 1'b1);
    chk("done_wr_count", bus.wr_count, 7'd32);
    chk("done_busy", bus.busy, 1'b0);

    // host readback in DONE
    bus.hr_valid = 1'b1; bus.hr_addr = 7'h0C; #1;
    chk("done_hr_ready", bus.hr_ready, 1'b1);
    chk("done_rd_addr", bus.ram_rd_addr, 7'h0C);
    rd_q.push_back(8'h2A);
    step(); bus.hr_valid = 1'b0;
    chk("hr_rvalid_next", bus.hr_rvalid, 1'b1);
    step();
    chk("hr_rvalid_drop", bus.hr_rvalid, 1'b0);

    // second run with a bubble, aborted at REDUCE cycle 40
    bus.start = 1'b1; step(); bus.start = 1'b0;
    chk("restart_wr_count", bus.wr_count, 7'd0);
    do_load(20);
    do_reduce(40);
    bus.abort = 1'b1; step(); bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_bc_mode", bus.bc_mode, 1'b1);
    chk("abort_wr_count", bus.wr_count, 7'd10);

    // start with abort in IDLE stays put
    bus.start = 1'b1; bus.abort = 1'b1; step();
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("start_abort_idle", bus.busy, 1'b0);

    // full run after abort
    bus.start = 1'b1; step(); bus.start = 1'b0;
    do_load(-1);
    do_reduce(128);
    chk("run3_done", bus.done, 1'b1);
    chk("run3_wr_count", bus.wr_count, 7'd32);

    // asynchronous reset in the middle of a load
    bus.start = 1'b1; step(); bus.start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      bus.ld_valid = 1'b1; bus.ld_data = k[7:0];
      wr_q.push_back({k[5:3], 1'b0, k[2:0], k[7:0]});
      step();
    end
    bus.ld_data = 8'd30;
    #2 RST = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_ld_ready", bus.ld_ready, 1'b0);
    chk("arst_ram_wen", bus.ram_wen, 1'b0);
    chk("arst_bc_mode", bus.bc_mode, 1'b1);
    chk("arst_done", bus.done, 1'b0);
    chk("arst_wr_count", bus.wr_count, 7'd0);
    bus.ld_valid = 1'b0;
    step(); RST = 1'b0; step();

    chk("wr_q_drained", wr_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
